// File: rtl/mem_word_responder.sv
// Word read/write responder over an internal byte-wide memory, two byte accesses per word.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject odd word addresses with err.
module mem_word_responder #(
  parameter int DEPTH  = 16384,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [15:0]       rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx_q;
  logic              we_q;
  logic [15:0]       wdata_q;
  logic              err_q;
  logic [7:0]        rdata_low;
  logic [15:0]       rd_word;
  logic              addr_bad;
  logic [IDX_W-1:0]  idx_hi;

  logic [7:0] mem [DEPTH];

  always_comb begin
    addr_bad = ({1'b0, addr} >= (ADDR_W+1)'(DEPTH));
`ifdef MEM_ALIGN_CHECK_EN
    if (addr[0]) addr_bad = 1'b1;
`else
    addr_bad = addr_bad;
`endif
  end

  // High byte wraps to address 0 when the low byte sits at the last location.
  assign idx_hi = (idx_q == IDX_W'(DEPTH - 1)) ? '0 : idx_q + IDX_W'(1);

  // rdata only updates in DONE so it stays stable between completions.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rdata_low <= '0;
      rd_word   <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack  <= 1'b0;
          err  <= 1'b0;
          busy <= req;
          if (req) begin
            idx_q   <= addr[IDX_W-1:0];
            we_q    <= we;
            wdata_q <= wdata;
            err_q   <= addr_bad;
            state   <= addr_bad ? DONE : BYTE0;
          end
        end
        BYTE0: begin
          if (!we_q) rdata_low <= mem[idx_q];
          state <= BYTE1;
        end
        BYTE1: begin
          if (!we_q) rd_word <= {mem[idx_hi], rdata_low};
          state <= DONE;
        end
        DONE: begin
          ack <= 1'b1;
          err <= err_q;
          if (err_q)      rdata <= '0;
          else if (!we_q) rdata <= rd_word;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory is deliberately left out of reset; reset forces IDLE so no write can slip through.
  always_ff @(posedge clock) begin
    if (we_q) begin
      if (state == BYTE0)      mem[idx_q]  <= wdata_q[7:0];
      else if (state == BYTE1) mem[idx_hi] <= wdata_q[15:8];
    end
  end

endmodule

// File: tb/tb_mem_word_responder.sv
// Scoreboard bench for mem_word_responder: stimulus pushes expectations, a negedge monitor checks acks.
module tb_mem_word_responder;

  localparam int DEPTH  = 16384;
  localparam int ADDR_W = 16;

  logic              clock   = 1'b0;
  logic              reset_n = 1'b0;
  logic              req     = 1'b0;
  logic              we      = 1'b0;
  logic [ADDR_W-1:0] addr    = '0;
  logic [15:0]       wdata   = '0;
  logic              busy;
  logic              ack;
  logic              err;
  logic [15:0]       rdata;

  mem_word_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .busy   (busy),
    .ack    (ack),
    .err    (err),
    .rdata  (rdata)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        is_read;
    logic        err;
    logic [15:0] rdata;
    int          ack_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && ack) begin
      if (sb.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_ack: got ack=1 at cycle %0d, expected no ack", cyc);
      end else begin
        e = sb.pop_front();
        check_output({e.name, "_ack_cycle"}, cyc, e.ack_cyc);
        check_output({e.name, "_err"}, {31'b0, err}, {31'b0, e.err});
        if (e.is_read || e.err)
          check_output({e.name, "_rdata"}, {16'b0, rdata}, {16'b0, e.rdata});
      end
    end
  end

  task automatic apply_stimulus(input string name, input logic w, input logic [15:0] a,
                                input logic [15:0] d, input logic exp_err, input logic [15:0] exp_rdata);
    int acc;
    int busy_cycles;
    int guard;
    @(negedge clock);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clock);
    acc = cyc;
    req = 1'b0; we = ~w; addr = a ^ 16'h3FFE; wdata = ~d;
    sb.push_back('{!w, exp_err, exp_rdata, acc + (exp_err ? 1 : 3), name});
    busy_cycles = 0;
    guard = 0;
    while (busy && guard < 12) begin
      busy_cycles++;
      guard++;
      @(negedge clock);
    end
    check_output({name, "_busy_cycles"}, busy_cycles, exp_err ? 2 : 4);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int guard;

    repeat (2) @(negedge clock);
    check_output("reset_busy",  {31'b0, busy}, 0);
    check_output("reset_ack",   {31'b0, ack},  0);
    check_output("reset_err",   {31'b0, err},  0);
    check_output("reset_rdata", {16'b0, rdata}, 0);
    reset_n = 1'b1;

    apply_stimulus("wr_beef", 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000);
    apply_stimulus("rd_beef", 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF);

    apply_stimulus("wr_1234", 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000);
    apply_stimulus("wr_5678", 1'b1, 16'h0022, 16'h5678, 1'b0, 16'h0000);
`ifdef MEM_ALIGN_CHECK_EN
    apply_stimulus("rd_odd21", 1'b0, 16'h0021, 16'h0000, 1'b1, 16'h0000);
    apply_stimulus("wr_odd11", 1'b1, 16'h0011, 16'hFFFF, 1'b1, 16'h0000);
    apply_stimulus("rd_after_odd", 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF);
`else
    apply_stimulus("rd_odd21", 1'b0, 16'h0021, 16'h0000, 1'b0, 16'h7812);
    apply_stimulus("wr_1111", 1'b1, 16'h0001, 16'h1111, 1'b0, 16'h0000);
    apply_stimulus("wr_wrap", 1'b1, 16'h3FFF, 16'hA55A, 1'b0, 16'h0000);
    apply_stimulus("rd_wrap", 1'b0, 16'h3FFF, 16'h0000, 1'b0, 16'hA55A);
    apply_stimulus("rd_zero", 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h11A5);
`endif

    apply_stimulus("rd_oob",    1'b0, 16'h4000, 16'h0000, 1'b1, 16'h0000);
    apply_stimulus("wr_oob",    1'b1, 16'h4000, 16'hDEAD, 1'b1, 16'h0000);
    apply_stimulus("rd_top",    1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000);
    apply_stimulus("rd_recheck", 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF);

    // Interrupted write: reset lands after the low byte is stored.
    apply_stimulus("wr_clear30", 1'b1, 16'h0030, 16'h0000, 1'b0, 16'h0000);
    @(negedge clock);
    req = 1'b1; we = 1'b1; addr = 16'h0030; wdata = 16'hCAFE;
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_output("midrst_busy",  {31'b0, busy}, 0);
    check_output("midrst_ack",   {31'b0, ack},  0);
    check_output("midrst_err",   {31'b0, err},  0);
    check_output("midrst_rdata", {16'b0, rdata}, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check_output("postrst_busy", {31'b0, busy}, 0);
    apply_stimulus("rd_partial", 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h00FE);

    // Back-to-back reads with req held high and the address alternating.
    @(negedge clock);
    req = 1'b1; we = 1'b0; addr = 16'h0010;
    @(negedge clock);
    acc = cyc;
    for (int k = 0; k < 4; k++)
      sb.push_back('{1'b1, 1'b0, (k % 2 == 1) ? 16'h1234 : 16'hBEEF, acc + 4 * k + 3, "b2b"});
    for (int k = 1; k <= 4; k++) begin
      if (k < 4) addr = (k % 2 == 1) ? 16'h0020 : 16'h0010;
      else       req  = 1'b0;
      repeat (4) @(negedge clock);
    end
    guard = 0;
    while (busy && guard < 12) begin
      guard++;
      @(negedge clock);
    end
    check_output("b2b_idle", {31'b0, busy}, 0);

    repeat (3) @(negedge clock);
    check_output("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mem_word_responder.md
# mem_word_responder

Memory-side responder for the 16-bit accumulator datapath. It accepts word read/write requests issued by the control unit through the MAR/MBR path. Each request is served as two sequential byte accesses to a byte-wide main memory array held inside the block. It returns a completion handshake with read data or an error flag.

## Interface
Parameters:
- DEPTH, 16384, number of bytes in the internal memory array; byte addresses valid in 0..DEPTH-1
- ADDR_W, 16, width of the request address

Ports:
- clock  input  1  single system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  1  request valid; held high by the initiator until ack
- we  input  1  1 = write, 0 = read; sampled with req
- addr  input  ADDR_W  byte address of the word's low byte
- wdata  input  16  write data, sampled with req
- busy  output  1  transaction in progress (not IDLE)
- ack  output  1  one-cycle completion pulse
- err  output  1  error status; valid while ack=1
- rdata  output  16  read data; valid while ack=1, held until next completion

## Operation
- Byte order is little-endian:
  - low byte at mem[a]
  - high byte at mem[(a+1) mod DEPTH]; a word at DEPTH-1 wraps its high byte to address 0
- FSM states: IDLE, BYTE0, BYTE1, DONE.
- IDLE, req=1:
  - latch addr, we, wdata into internal registers; busy <= 1
  - if addr >= DEPTH (or misaligned, see Configuration): go to DONE with error
  - otherwise go to BYTE0
- IDLE, req=0: stay in IDLE.
- BYTE0:
  - write: mem[a] <= wdata[7:0]
  - read: rdata_low <= mem[a]
  - then go to BYTE1
- BYTE1:
  - write: mem[a+1] <= wdata[15:8]
  - read: rdata <= {mem[a+1], rdata_low}
  - then go to DONE
- DONE, registered on entry:
  - ack = 1 for exactly one cycle; busy stays 1 during DONE
  - err = 1 on the error path, else 0
  - error path: rdata <= 0; memory is never modified
  - then go to IDLE
- Inputs are ignored outside IDLE. Changing addr, we or wdata mid-transaction has no effect.
- If req is still high in IDLE after ack, it is taken as a new request.
- Throughput is at most one transaction every 4 cycles.
- Memory contents are not initialised by reset. A bench must write before it reads.

## Timing
- Reset values: busy=0, ack=0, err=0, rdata=16'h0000, state=IDLE.
- Normal access, with acceptance at rising edge E0:
  - BYTE0 at E1, BYTE1 at E2
  - ack high from E3 to E4; busy falls at E4
- Error access: ack high from E1 to E2.
- Reset asserted mid-transaction:
  - immediate return to IDLE; all outputs go to their reset values; no ack is produced
  - a write interrupted after BYTE0 leaves the low byte written and the high byte unchanged (partial write is permitted and documented)
- Deasserting req before ack does not abort the transaction. ack is still produced.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - a request with addr[0]=1 takes the error path: err=1 with ack, rdata=0, no memory change
  - the wrap case at DEPTH-1 is therefore unreachable for even DEPTH
- MEM_ALIGN_CHECK_EN undefined:
  - odd addresses are legal and access bytes a and a+1 mod DEPTH
  - err is raised only for addr >= DEPTH

## Test plan
- Write 16'hBEEF at 0x0010, then read 0x0010 -> rdata=16'hBEEF, err=0; ack exactly 3 edges after each acceptance edge; busy high for 4 cycles.
- Write 16'h1234 at 0x0020 and 16'h5678 at 0x0022, then read 0x0021:
  - macro off -> rdata=16'h7812, err=0
  - macro on -> err=1, rdata=0
- Macro off: write 16'hA55A at 0x3FFF -> reading 0x3FFF returns 16'hA55A, and reading 0x0000 returns low byte 0xA5 (read 0x0000 after first writing 0x0001 with a known value).
- Read 0x4000 with DEPTH=16384 -> ack 1 edge after acceptance, err=1, rdata=0. A prior read of 0x0010 still returns its data, confirming no memory side effect.
- Write 16'hCAFE at 0x0030 with old contents 16'h0000, and assert reset_n=0 one cycle after BYTE0 executes:
  - all outputs zero, no ack
  - a subsequent read of 0x0030 returns 16'h00FE
- Hold req=1 continuously with alternating addresses -> back-to-back transactions accepted at the IDLE edge right after each DONE; one ack per 4 cycles; no request lost or duplicated.
